// File: rtl/key_scan_sched_pkg.sv
// Shared definitions for the key_scan / key_pad / key_scan_sched matrix path:
// sequencer state encodings, default key width and a width helper.
package key_scan_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } sched_state_t;

  localparam int KEY_W_DEF = 5;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous show-ahead FIFO for key events; the head is visible on o_data
// while o_vld is high and the last popped code is held once it drains.
module key_evt_fifo
  import key_scan_sched_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [KEY_W-1:0] i_data,
  input  logic             i_pop,
  output logic             o_vld,
  output logic [KEY_W-1:0] o_data,
  output logic             o_full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [KEY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [KEY_W-1:0] r_last;

  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);

  assign o_vld  = !w_empty;
  assign o_data = w_empty ? r_last : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the pointers and count define what is valid,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: every register in a clocked block uses <=, so all of them sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_scan_sched.sv
// Strobe generator and scan-run sequencer for key_scan, plus the event FIFO
// that buffers nkpls/nkv for the host.
module key_scan_sched
  import key_scan_sched_pkg::*;
#(
  parameter int CLK_DIV    = 100,
  parameter int FRM_DIV    = 100,
  parameter int SCAN_SLOTS = 8,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  output logic             pls100k,
  output logic             pls1k,
  input  logic             nkpls,
  input  logic [KEY_W-1:0] nkv,
  output logic             key_vld,
  output logic [KEY_W-1:0] key_code,
  input  logic             key_rd,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             busy
);

  localparam int DIV_W  = clog2_min1(CLK_DIV);
  localparam int FRM_W  = clog2_min1(FRM_DIV);
  localparam int SLOT_W = clog2_min1(SCAN_SLOTS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(FRM_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SCAN_SLOTS);

  sched_state_t      r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [FRM_W-1:0]  r_frm_cnt;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic              r_frm_seen;
  logic              r_pls100k;
  logic              r_pls1k;
  logic              r_ovf;

  logic w_div_wrap;
  logic w_frm_wrap;
  logic w_stop_done;
  logic w_fifo_full;
  logic w_drop;

  assign w_div_wrap  = (r_div_cnt == DIV_LAST);
  assign w_frm_wrap  = (r_frm_cnt == FRM_LAST);
  // Leave STOP once the frame in flight has had its slots, or at once if no
  // frame was ever started since IDLE.
  assign w_stop_done = !scan_en && (!r_frm_seen || (r_slot_cnt >= SLOT_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_div_cnt  <= '0;
      r_frm_cnt  <= '0;
      r_slot_cnt <= '0;
      r_frm_seen <= 1'b0;
      r_pls100k  <= 1'b0;
      r_pls1k    <= 1'b0;
    end else begin
      r_pls100k <= 1'b0;
      r_pls1k   <= 1'b0;
      case (r_state)
        ST_RUN, ST_STOP: begin
          if (r_state == ST_STOP && w_stop_done) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_frm_cnt  <= '0;
            r_slot_cnt <= '0;
            r_frm_seen <= 1'b0;
          end else begin
            if (r_state == ST_RUN && !scan_en)     r_state <= ST_STOP;
            else if (r_state == ST_STOP && scan_en) r_state <= ST_RUN;

            if (w_div_wrap) begin
              r_div_cnt <= '0;
              r_pls100k <= 1'b1;
              if (w_frm_wrap) r_frm_cnt <= '0;
              else            r_frm_cnt <= r_frm_cnt + 1'b1;
              // Frame starts only in RUN; in STOP the wrap counts as a plain slot.
              if (w_frm_wrap && r_state == ST_RUN) begin
                r_pls1k    <= 1'b1;
                r_slot_cnt <= '0;
                r_frm_seen <= 1'b1;
              end else if (r_slot_cnt < SLOT_MAX) begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
              end
            end else begin
              r_div_cnt <= r_div_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state    <= scan_en ? ST_RUN : ST_IDLE;
          r_div_cnt  <= '0;
          r_frm_cnt  <= '0;
          r_slot_cnt <= '0;
          r_frm_seen <= 1'b0;
        end
      endcase
    end
  end

  assign pls100k = r_pls100k;
  assign pls1k   = r_pls1k;
  assign busy    = (r_state != ST_IDLE);

  key_evt_fifo #(
    .KEY_W (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (nkpls),
    .i_data (nkv),
    .i_pop  (key_rd),
    .o_vld  (key_vld),
    .o_data (key_code),
    .o_full (w_fifo_full)
  );

  assign w_drop = nkpls && w_fifo_full && !(key_rd && key_vld);

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;

endmodule

// File: tb/tb_key_scan_sched.sv
// Directed bench for key_scan_sched: strobe timing, stop sequencing, and the
// event FIFO checked against a queue scoreboard.
module tb_key_scan_sched;

  localparam int KW    = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_en;
  logic          pls100k;
  logic          pls1k;
  logic          nkpls;
  logic [KW-1:0] nkv;
  logic          key_vld;
  logic [KW-1:0] key_code;
  logic          key_rd;
  logic          ovf;
  logic          ovf_clr;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [KW-1:0] exp_q[$];
  logic [KW-1:0] last_code = '0;
  logic          exp_ovf   = 1'b0;

  key_scan_sched #(
    .CLK_DIV    (4),
    .FRM_DIV    (5),
    .SCAN_SLOTS (3),
    .KEY_W      (KW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .pls100k  (pls100k),
    .pls1k    (pls1k),
    .nkpls    (nkpls),
    .nkv      (nkv),
    .key_vld  (key_vld),
    .key_code (key_code),
    .key_rd   (key_rd),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One cycle of FIFO stimulus; the scoreboard is updated as it is driven.
  task automatic drive(input bit push, input logic [KW-1:0] v, input bit rd, input bit clr);
    bit pop_ok;
    bit drop;
    nkpls   = push;
    nkv     = v;
    key_rd  = rd;
    ovf_clr = clr;
    pop_ok  = rd && (exp_q.size() != 0);
    drop    = push && (exp_q.size() == DEPTH) && !pop_ok;
    if (pop_ok) last_code = exp_q.pop_front();
    if (push && !drop) exp_q.push_back(v);
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    step();
    nkpls   = 1'b0;
    key_rd  = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic check_fifo(input string tag);
    logic [KW-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : last_code;
    check({tag, " vld"}, 32'(key_vld), 32'(exp_q.size() != 0));
    check({tag, " code"}, 32'(key_code), 32'(head));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic run_count(input int n, output int n100, output int n1k, output int first100);
    n100 = 0;
    n1k = 0;
    first100 = -1;
    for (int c = 0; c < n; c++) begin
      step();
      if (pls100k) begin
        if (first100 < 0) first100 = c;
        n100++;
      end
      if (pls1k) n1k++;
    end
  endtask

  initial begin
    int n100, n1k, first100, first1k, bad, waited;

    rst = 1'b1; scan_en = 1'b0; nkpls = 1'b0; nkv = '0; key_rd = 1'b0; ovf_clr = 1'b0;
    step();
    step();
    check("reset pls100k", 32'(pls100k), 32'd0);
    check("reset pls1k", 32'(pls1k), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check_fifo("reset");

    // Strobe cadence and first frame start.
    rst = 1'b0;
    scan_en = 1'b1;
    bad = 0; n100 = 0; n1k = 0; first1k = -1;
    for (int c = 0; c <= 20; c++) begin
      step();
      if (pls100k !== ((c > 0) && (c % 4 == 0))) bad++;
      if (pls100k) n100++;
      if (pls1k) begin
        n1k++;
        if (first1k < 0) first1k = c;
      end
    end
    check("t1 pls100k period errors", 32'(bad), 32'd0);
    check("t1 pls100k count", 32'(n100), 32'd5);
    check("t1 first pls1k clk", 32'(first1k), 32'd20);
    check("t1 pls1k count", 32'(n1k), 32'd1);
    check("t1 pls1k with 5th pls100k", 32'(pls100k), 32'd1);
    check("t1 busy", 32'(busy), 32'd1);

    // Stop one strobe after the frame start.
    waited = 0;
    do begin
      step();
      waited++;
    end while (!pls100k && waited < 10);
    check("t2 next pls100k gap", 32'(waited), 32'd4);
    scan_en = 1'b0;
    run_count(30, n100, n1k, first100);
    check("t2 pls100k after stop", 32'(n100), 32'd2);
    check("t2 pls1k after stop", 32'(n1k), 32'd0);
    check("t2 busy after stop", 32'(busy), 32'd0);

    // Stop before any frame start returns straight to IDLE.
    scan_en = 1'b1;
    repeat (6) step();
    check("t2b busy running", 32'(busy), 32'd1);
    scan_en = 1'b0;
    step();
    step();
    check("t2b busy early stop", 32'(busy), 32'd0);

    // FIFO ordering and show-ahead.
    drive(1'b1, 5'h03, 1'b0, 1'b0);
    check_fifo("t3 first push");
    drive(1'b1, 5'h11, 1'b0, 1'b0);
    drive(1'b1, 5'h1F, 1'b0, 1'b0);
    check("t3 head", 32'(key_code), 32'h03);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("t3 pop1 code", 32'(key_code), 32'h11);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("t3 pop2 code", 32'(key_code), 32'h1F);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("t3 drained vld", 32'(key_vld), 32'd0);
    check("t3 held code", 32'(key_code), 32'h1F);
    drive(1'b0, '0, 1'b1, 1'b0);
    check_fifo("t3 pop empty");

    // Overflow, push+pop at full, and flag priority.
    for (int i = 1; i <= 4; i++) drive(1'b1, KW'(i), 1'b0, 1'b0);
    check("t4 ovf at full", 32'(ovf), 32'd0);
    drive(1'b1, 5'h05, 1'b0, 1'b0);
    check("t4 ovf after drop", 32'(ovf), 32'd1);
    check_fifo("t4 drop");
    drive(1'b0, '0, 1'b0, 1'b1);
    check("t4 ovf cleared", 32'(ovf), 32'd0);
    drive(1'b1, 5'h0A, 1'b1, 1'b0);
    check("t4 push+pop full ovf", 32'(ovf), 32'd0);
    check_fifo("t4 push+pop full");
    drive(1'b1, 5'h0B, 1'b0, 1'b1);
    check("t4 set beats clr", 32'(ovf), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("t4 ovf clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 6 && key_vld; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check_fifo("t4 drain");
    end
    check("t4 drained last", 32'(key_code), 32'h0A);

    // Reset mid-frame with queued events.
    scan_en = 1'b1;
    repeat (10) step();
    drive(1'b1, 5'h07, 1'b0, 1'b0);
    drive(1'b1, 5'h09, 1'b0, 1'b0);
    check_fifo("t5 before rst");
    rst = 1'b1;
    scan_en = 1'b0;
    step();
    exp_q.delete();
    last_code = '0;
    exp_ovf = 1'b0;
    check("t5 busy", 32'(busy), 32'd0);
    check("t5 pls100k", 32'(pls100k), 32'd0);
    check_fifo("t5 after rst");
    rst = 1'b0;
    run_count(30, n100, n1k, first100);
    check("t5 idle pls100k", 32'(n100), 32'd0);
    check("t5 idle pls1k", 32'(n1k), 32'd0);
    scan_en = 1'b1;
    run_count(6, n100, n1k, first100);
    check("t5 restart first pls100k", 32'(first100), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
